// File: rtl/serial_addsub_unit.sv
// rtl/serial_addsub_unit.sv - bit-serial add/subtract engine with ARM NZCV flags
module serial_addsub_unit #(
    parameter  int WIDTH = 64,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flagN,
    output logic             flagZ,
    output logic             flagC,
    output logic             flagV
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             sub_reg;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt;

    logic             slice_b;
    logic             slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] next_result;
    logic             last_bit;

    // One full adder/subtractor slice: B is inverted on subtract, carry-in seeded with sub
    always_comb begin
        slice_b     = b_sh[0] ^ sub_reg;
        slice_sum   = a_sh[0] ^ slice_b ^ carry_reg;
        slice_cout  = (a_sh[0] & slice_b) | (carry_reg & (a_sh[0] ^ slice_b));
        next_result = {slice_sum, result[WIDTH-1:1]};
        last_bit    = (cnt == CNT_W'(WIDTH - 1));
    end

    // Control FSM plus datapath; status outputs are registered alongside the state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            sub_reg   <= 1'b0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            flagN     <= 1'b0;
            flagZ     <= 1'b0;
            flagC     <= 1'b0;
            flagV     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh      <= A;
                        b_sh      <= B;
                        sub_reg   <= sub;
                        carry_reg <= sub;
                        cnt       <= '0;
                        result    <= '0;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    a_sh      <= a_sh >> 1;
                    b_sh      <= b_sh >> 1;
                    result    <= next_result;
                    carry_reg <= slice_cout;
                    cnt       <= cnt + 1'b1;
                    if (last_bit) begin
                        // carry_reg still holds the carry into the MSB at this point
                        flagC <= slice_cout;
                        flagV <= carry_reg ^ slice_cout;
                        flagN <= slice_sum;
                        flagZ <= (next_result == '0);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// tb/tb_serial_addsub_unit.sv - scoreboard bench for serial_addsub_unit
module tb_serial_addsub_unit;

    localparam int WIDTH = 64;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             flagN;
    logic             flagZ;
    logic             flagC;
    logic             flagV;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [3:0]       nzcv;
    } exp_t;

    exp_t       sb_q[$];
    int         total;
    int         bad;
    int         dones;
    logic [3:0] last_nzcv;

    serial_addsub_unit #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .sub     (sub),
        .A       (A),
        .B       (B),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .flagN   (flagN),
        .flagZ   (flagZ),
        .flagC   (flagC),
        .flagV   (flagV)
    );

    initial clk = 1'b0;
    always #500 clk = ~clk;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is compared against the oldest queued expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            dones++;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                e = sb_q.pop_front();
                chk("sb_result", result, e.res);
                chk("sb_nzcv", 64'({flagN, flagZ, flagC, flagV}), 64'(e.nzcv));
                chk("sb_ready_low", 64'(ready), 64'd0);
                chk("sb_busy_low", 64'(busy), 64'd0);
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 64'(ready), 64'd1);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                          input logic [WIDTH-1:0] exp_res, input logic [3:0] exp_nzcv,
                          input bit intrude);
        int cyc;
        int busy_cnt;
        int dones_before;
        @(negedge clk);
        wait_ready();
        dones_before = dones;
        A = a;
        B = b;
        sub = s;
        start = 1'b1;
        sb_q.push_back('{res: exp_res, nzcv: exp_nzcv});
        @(negedge clk);
        start = 1'b0;
        A = ~a;
        B = ~b;
        sub = ~s;
        chk("start_result_clear", result, '0);
        chk("start_flags_hold", 64'({flagN, flagZ, flagC, flagV}), 64'(last_nzcv));
        cyc = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && cyc < 200) begin
            if (busy === 1'b1) busy_cnt++;
            if (intrude && cyc == 10) begin
                A = 64'h1;
                B = 64'h1;
                sub = 1'b1;
                start = 1'b1;
            end
            if (intrude && cyc == 11) start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(WIDTH));
        chk("busy_cycles", 64'(busy_cnt), 64'(WIDTH));
        @(negedge clk);
        chk("done_single", 64'(done), 64'd0);
        chk("ready_after", 64'(ready), 64'd1);
        chk("result_hold", result, exp_res);
        repeat (3) @(negedge clk);
        chk("done_count", 64'(dones - dones_before), 64'd1);
        chk("hold_later", result, exp_res);
        last_nzcv = exp_nzcv;
    endtask

    initial begin
        int dones_before;
        total = 0;
        bad = 0;
        dones = 0;
        last_nzcv = 4'b0000;
        start = 1'b0;
        sub = 1'b0;
        A = '0;
        B = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", result, '0);
        chk("rst_nzcv", 64'({flagN, flagZ, flagC, flagV}), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op(64'd5, 64'd3, 1'b0, 64'd8, 4'b0000, 1'b0);
        run_op(64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0);
        run_op(64'd5, 64'd5, 1'b1, 64'd0, 4'b0110, 1'b0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001, 1'b0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b0110, 1'b0);
        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1'b0);
        run_op(64'h10, 64'h20, 1'b0, 64'h30, 4'b0000, 1'b1);

        // Abort mid-run with reset: no done pulse, everything back to idle values
        @(negedge clk);
        wait_ready();
        dones_before = dones;
        A = 64'd7;
        B = 64'd9;
        sub = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_ready", 64'(ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_result", result, '0);
        chk("abort_nzcv", 64'({flagN, flagZ, flagC, flagV}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (80) @(negedge clk);
        chk("abort_no_done", 64'(dones - dones_before), 64'd0);
        last_nzcv = 4'b0000;
        run_op(64'd5, 64'd3, 1'b0, 64'd8, 4'b0000, 1'b0);

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
